bubble_sort_stream: RTL

//   Sequential, registered counterpart of the combinational bubble sorter. It

---
 rtl/bubble_sort_stream.sv | 117 +++++++++++
 1 files changed

// File: rtl/bubble_sort_stream.sv
// bubble_sort_stream: serial-in, serial-out block sorter using odd-even transposition, one phase per clock.
// Define EARLY_EXIT_EN to leave SORT after two consecutive swap-free phases.
module bubble_sort_stream #(
    parameter int DIM   = 10,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy
);
    localparam int CW = $clog2(DIM);
    localparam logic [CW-1:0] LAST = CW'(DIM - 1);

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    ph_q, ph_d;
    logic [WIDTH-1:0] slot_q [DIM];
    logic [WIDTH-1:0] slot_d [DIM];
`ifdef EARLY_EXIT_EN
    logic             clean_q, clean_d;
    logic             swapped;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            idx_q   <= '0;
            ph_q    <= '0;
`ifdef EARLY_EXIT_EN
            clean_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ph_q    <= ph_d;
`ifdef EARLY_EXIT_EN
            clean_q <= clean_d;
`endif
        end
    end

    // Array contents are don't-care after reset, so they carry no reset.
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ph_d      = ph_q;
        slot_d    = slot_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
`ifdef EARLY_EXIT_EN
        clean_d   = clean_q;
        swapped   = 1'b0;
`endif
        case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    slot_d[idx_q] = in_data;
                    idx_d         = (idx_q == LAST) ? '0 : idx_q + CW'(1);
                    state_d       = (idx_q == LAST) ? SORT : LOAD;
`ifdef EARLY_EXIT_EN
                    clean_d       = 1'b0;
`endif
                end
            end
            SORT: begin
                busy = 1'b1;
                // Pairs start on even k in even phases and odd k in odd phases; they never overlap.
                for (int k = 0; k < DIM - 1; k++) begin
                    if (((k % 2) == int'(ph_q[0])) && (slot_q[k] > slot_q[k+1])) begin
                        slot_d[k]   = slot_q[k+1];
                        slot_d[k+1] = slot_q[k];
`ifdef EARLY_EXIT_EN
                        swapped     = 1'b1;
`endif
                    end
                end
                ph_d    = (ph_q == LAST) ? '0 : ph_q + CW'(1);
                state_d = (ph_q == LAST) ? DRAIN : SORT;
`ifdef EARLY_EXIT_EN
                clean_d = !swapped;
                if (!swapped && clean_q) begin
                    ph_d    = '0;
                    state_d = DRAIN;
                end
`endif
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = slot_q[idx_q];
                out_last  = (idx_q == LAST);
                if (out_ready) begin
                    idx_d   = (idx_q == LAST) ? '0 : idx_q + CW'(1);
                    state_d = (idx_q == LAST) ? LOAD : DRAIN;
                end
            end
            default: state_d = LOAD;
        endcase
    end
endmodule
